// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS control unit:
// state codes, opcodes, datapath select values and the packed control word.
package mips_ctrl_pkg;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADDR = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_RTEXEC  = 4'd7;
  localparam logic [3:0] S_RTWB    = 4'd8;
  localparam logic [3:0] S_IMMEXEC = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_BRANCH  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  // States whose exit edge completes an instruction.
  function automatic logic retires(input logic [3:0] st);
    return (st == S_MEMWB) || (st == S_MEMWR) || (st == S_RTWB) ||
           (st == S_IMMWB) || (st == S_BRANCH) || (st == S_JUMP);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit (master) and the datapath (slave):
// start/opcode toward control, selects/strobes/debug back to the datapath.
interface multicycle_control_if #(parameter int RETIRE_W = 32);

  logic                start_i;
  logic [5:0]          Op_i;
  logic                PCWrite_o;
  logic                PCWriteCond_o;
  logic                IorD_o;
  logic                MemRead_o;
  logic                MemWrite_o;
  logic                IRWrite_o;
  logic                MemtoReg_o;
  logic                RegDst_o;
  logic                RegWrite_o;
  logic                ALUSrcA_o;
  logic [1:0]          ALUSrcB_o;
  logic [1:0]          ALUOp_o;
  logic [1:0]          PCSource_o;
  logic                illegal_o;
  logic [3:0]          state_o;
  logic [RETIRE_W-1:0] retired_o;

  modport master (
    input  start_i, Op_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, illegal_o, state_o, retired_o
  );

  modport slave (
    output start_i, Op_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, illegal_o, state_o, retired_o
  );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational Moore decode of the FSM state into datapath controls;
// the opcode only matters in DECODE, where it flags unsupported instructions.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = !op_supported(op);
      end
      S_MEMADDR, S_IMMEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_RTEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state sequencing and the
// retired-instruction counter; output decode lives in multicycle_ctrl_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multicycle_control_if.master  bus
);

  logic [3:0]          state;
  logic [3:0]          state_next;
  logic [RETIRE_W-1:0] retired;
  ctrl_t               ctrl;

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_IDLE:   state_next = bus.start_i ? S_FETCH : S_IDLE;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op_i)
          OP_RTYPE:     state_next = S_RTEXEC;
          OP_ADDI:      state_next = S_IMMEXEC;
          OP_LW, OP_SW: state_next = S_MEMADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      // The IR still holds the opcode here, so lw/sw can split without a flag.
      S_MEMADDR: state_next = (bus.Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_RTEXEC:  state_next = S_RTWB;
      S_IMMEXEC: state_next = S_IMMWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired <= '0;
    end else if (retires(state)) begin
      retired <= retired + RETIRE_W'(1);
    end
  end

  multicycle_ctrl_decode u_decode (
    .state (state),
    .op    (bus.Op_i),
    .ctrl  (ctrl)
  );

  assign bus.PCWrite_o     = ctrl.pc_write;
  assign bus.PCWriteCond_o = ctrl.pc_write_cond;
  assign bus.IorD_o        = ctrl.i_or_d;
  assign bus.MemRead_o     = ctrl.mem_read;
  assign bus.MemWrite_o    = ctrl.mem_write;
  assign bus.IRWrite_o     = ctrl.ir_write;
  assign bus.MemtoReg_o    = ctrl.mem_to_reg;
  assign bus.RegDst_o      = ctrl.reg_dst;
  assign bus.RegWrite_o    = ctrl.reg_write;
  assign bus.ALUSrcA_o     = ctrl.alu_src_a;
  assign bus.ALUSrcB_o     = ctrl.alu_src_b;
  assign bus.ALUOp_o       = ctrl.alu_op;
  assign bus.PCSource_o    = ctrl.pc_source;
  assign bus.illegal_o     = ctrl.illegal;
  assign bus.state_o       = state;
  assign bus.retired_o     = retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks lw, R-type, sw, beq, illegal,
// mid-instruction reset and counter wrap with a 4-bit retire counter.
module tb_multicycle_control;

  localparam int RW = 4;

  // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA | ALUSrcB | ALUOp | PCSource | illegal
  localparam logic [16:0] V_IDLE    = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] V_FETCH   = 17'b1001010000_01_00_00_0;
  localparam logic [16:0] V_DECODE  = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] V_DEC_ILL = 17'b0000000000_11_00_00_1;
  localparam logic [16:0] V_MEMADDR = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] V_MEMRD   = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] V_MEMWB   = 17'b0000001010_00_00_00_0;
  localparam logic [16:0] V_MEMWR   = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] V_RTEXEC  = 17'b0000000001_00_10_00_0;
  localparam logic [16:0] V_RTWB    = 17'b0000000110_00_00_00_0;
  localparam logic [16:0] V_IMMEXEC = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] V_BRANCH  = 17'b0100000001_00_01_01_0;
  localparam logic [16:0] V_JUMP    = 17'b1000000000_00_00_10_0;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  logic [16:0] ctrl_vec;

  multicycle_control_if #(.RETIRE_W(RW)) bus ();

  multicycle_control #(.RETIRE_W(RW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {bus.PCWrite_o, bus.PCWriteCond_o, bus.IorD_o, bus.MemRead_o,
                     bus.MemWrite_o, bus.IRWrite_o, bus.MemtoReg_o, bus.RegDst_o,
                     bus.RegWrite_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUOp_o,
                     bus.PCSource_o, bus.illegal_o};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [5:0] op);
    bus.start_i = start;
    bus.Op_i    = op;
  endtask

  // Advance to the next falling edge and compare state and full control word.
  task automatic expectStep(input string tag, input logic [3:0] st,
                            input logic [16:0] vec);
    @(negedge clk);
    checkOutput({tag, ".state"}, 32'(bus.state_o), 32'(st));
    checkOutput({tag, ".ctrl"}, 32'(ctrl_vec), 32'(vec));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 6'b000000);
    repeat (2) @(negedge clk);
    checkOutput("reset.state", 32'(bus.state_o), 32'd0);
    checkOutput("reset.retired", 32'(bus.retired_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      expectStep("idle_hold", 4'd0, V_IDLE);
    end
    checkOutput("idle.retired", 32'(bus.retired_o), 32'd0);

    // lw: FETCH -> DECODE -> MEMADDR -> MEMRD -> MEMWB -> FETCH
    applyStimulus(1'b1, 6'b100011);
    expectStep("start.fetch", 4'd1, V_FETCH);
    applyStimulus(1'b0, 6'b100011);
    expectStep("lw.decode", 4'd2, V_DECODE);
    expectStep("lw.memaddr", 4'd3, V_MEMADDR);
    expectStep("lw.memrd", 4'd4, V_MEMRD);
    checkOutput("lw.retired_pre", 32'(bus.retired_o), 32'd0);
    expectStep("lw.memwb", 4'd5, V_MEMWB);
    expectStep("lw.fetch", 4'd1, V_FETCH);
    checkOutput("lw.retired", 32'(bus.retired_o), 32'd1);

    applyStimulus(1'b0, 6'b000000);
    expectStep("rt.decode", 4'd2, V_DECODE);
    expectStep("rt.exec", 4'd7, V_RTEXEC);
    expectStep("rt.wb", 4'd8, V_RTWB);
    expectStep("rt.fetch", 4'd1, V_FETCH);

    applyStimulus(1'b0, 6'b101011);
    expectStep("sw.decode", 4'd2, V_DECODE);
    expectStep("sw.memaddr", 4'd3, V_MEMADDR);
    expectStep("sw.memwr", 4'd6, V_MEMWR);
    expectStep("sw.fetch", 4'd1, V_FETCH);

    applyStimulus(1'b0, 6'b000100);
    expectStep("beq.decode", 4'd2, V_DECODE);
    expectStep("beq.branch", 4'd11, V_BRANCH);
    expectStep("beq.fetch", 4'd1, V_FETCH);
    checkOutput("beq.retired", 32'(bus.retired_o), 32'd4);

    applyStimulus(1'b0, 6'b001000);
    expectStep("addi.decode", 4'd2, V_DECODE);
    expectStep("addi.exec", 4'd9, V_IMMEXEC);
    expectStep("addi.wb", 4'd10, V_IMMWB_VALUE());
    expectStep("addi.fetch", 4'd1, V_FETCH);
    checkOutput("addi.retired", 32'(bus.retired_o), 32'd5);

    // Unsupported opcode: flagged only in DECODE, straight back to FETCH.
    applyStimulus(1'b1, 6'b111111);
    expectStep("ill.decode", 4'd2, V_DEC_ILL);
    expectStep("ill.fetch", 4'd1, V_FETCH);
    checkOutput("ill.retired", 32'(bus.retired_o), 32'd5);
    applyStimulus(1'b0, 6'b100011);

    expectStep("rst.decode", 4'd2, V_DECODE);
    expectStep("rst.memaddr", 4'd3, V_MEMADDR);
    expectStep("rst.memrd", 4'd4, V_MEMRD);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid.state", 32'(bus.state_o), 32'd0);
    checkOutput("rst_mid.ctrl", 32'(ctrl_vec), 32'(V_IDLE));
    checkOutput("rst_mid.retired", 32'(bus.retired_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expectStep("rst.idle", 4'd0, V_IDLE);

    // Sixteen jumps wrap the 4-bit counter back to zero.
    applyStimulus(1'b1, 6'b000010);
    expectStep("j.start", 4'd1, V_FETCH);
    applyStimulus(1'b0, 6'b000010);
    for (int i = 0; i < 16; i++) begin
      expectStep("j.decode", 4'd2, V_DECODE);
      expectStep("j.jump", 4'd12, V_JUMP);
      expectStep("j.fetch", 4'd1, V_FETCH);
      checkOutput("j.retired", 32'(bus.retired_o), 32'((i + 1) % 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [16:0] V_IMMWB_VALUE();
    return 17'b0000000010_00_00_00_0;
  endfunction

endmodule
